lfsr8_ctrl: RTL



---
 rtl/lfsr8_ctrl_pkg.sv | 17 +
 rtl/lfsr8_ctrl_if.sv | 20 ++
 rtl/lfsr8_ctrl_bitpack.sv | 38 +++
 rtl/lfsr8_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/lfsr8_ctrl_pkg.sv
// Shared types and constants for the LFSR8 sequencing controller.
package lfsr8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESEED  = 3'd1,
        ST_WARMUP  = 3'd2,
        ST_COLLECT = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int          RESEED_CYCLES = 2;
    localparam logic [7:0]  LFSR_SEED     = 8'h06;
    // First packed byte after a reseed with no warm-up (LSB = first bit).
    localparam logic [7:0]  FIRST_BYTE    = 8'hB2;

endpackage

// File: rtl/lfsr8_ctrl_if.sv
// Byte output port of the LFSR8 controller: valid/ready handshake.
interface lfsr8_ctrl_if;

    logic [7:0] BYTE_OUT;
    logic       BYTE_VALID;
    logic       BYTE_READY;

    modport master (
        output BYTE_OUT,
        output BYTE_VALID,
        input  BYTE_READY
    );

    modport slave (
        input  BYTE_OUT,
        input  BYTE_VALID,
        output BYTE_READY
    );

endinterface

// File: rtl/lfsr8_ctrl_bitpack.sv
// Serial-to-byte packer: bit counter selects the position of each incoming bit.
module lfsr8_ctrl_bitpack (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clr,
    input  logic       shift,
    input  logic       bit_in,
    output logic       last,
    output logic [7:0] byte_next
);

    logic [2:0] cnt;
    logic [7:0] data;

    always_ff @(posedge CLK) begin
        if (!RESET || clr) begin
            cnt <= 3'd0;
        end else if (shift) begin
            cnt <= cnt + 3'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            data <= 8'h00;
        end else if (shift) begin
            data[cnt] <= bit_in;
        end
    end

    // Completed byte including the bit arriving this cycle.
    always_comb begin
        byte_next      = data;
        byte_next[cnt] = bit_in;
        last           = (cnt == 3'd7);
    end

endmodule

// File: rtl/lfsr8_ctrl.sv
// LFSR8 sequencing controller: reseed, warm-up discard, byte packing, valid/ready output.
// Optional build macro LFSR8_CTRL_PERIOD_CNT_EN enables the PERIOD_CNT counter.
module lfsr8_ctrl
    import lfsr8_ctrl_pkg::*;
#(
    parameter int WARMUP = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_START,
    input  logic        CMD_STOP,
    input  logic        CMD_RESEED,
    input  logic        LFSR_BIT,
    input  logic        LFSR_PERIOD,
    output logic        LFSR_EN,
    output logic        LFSR_RST,
    output logic        BUSY,
    output logic [7:0]  PERIOD_CNT,
    lfsr8_ctrl_if.master byte_if
);

    state_t     state;
    logic [1:0] rs_cnt;
    logic [7:0] wu_cnt;
    logic [7:0] byte_out;
    logic [7:0] pending;
    logic       byte_valid;
    logic       active;

    logic       pack_shift;
    logic       pack_clr;
    logic       pack_last;
    logic [7:0] pack_byte;

    assign byte_if.BYTE_OUT   = byte_out;
    assign byte_if.BYTE_VALID = byte_valid;

    always_comb begin
        pack_shift = (state == ST_COLLECT);
        pack_clr   = (state == ST_RESEED);
        active     = (state == ST_WARMUP) || (state == ST_COLLECT) || (state == ST_HOLD);
    end

    lfsr8_ctrl_bitpack u_bitpack (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr       (pack_clr),
        .shift     (pack_shift),
        .bit_in    (LFSR_BIT),
        .last      (pack_last),
        .byte_next (pack_byte)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            rs_cnt     <= 2'd0;
            wu_cnt     <= 8'd0;
            LFSR_EN    <= 1'b0;
            LFSR_RST   <= 1'b0;
            BUSY       <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            // A handshake consumes the current byte; a load below re-asserts valid.
            if (byte_valid && byte_if.BYTE_READY) begin
                byte_valid <= 1'b0;
            end

            if (CMD_STOP) begin
                state    <= ST_IDLE;
                LFSR_EN  <= 1'b0;
                LFSR_RST <= 1'b0;
                BUSY     <= 1'b0;
            end else if (CMD_RESEED && active) begin
                state    <= ST_RESEED;
                rs_cnt   <= 2'd0;
                LFSR_EN  <= 1'b0;
                LFSR_RST <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (CMD_START) begin
                            state    <= ST_RESEED;
                            rs_cnt   <= 2'd0;
                            BUSY     <= 1'b1;
                        end
                    end
                    ST_RESEED: begin
                        if (rs_cnt == 2'(RESEED_CYCLES - 1)) begin
                            LFSR_EN  <= 1'b1;
                            LFSR_RST <= 1'b1;
                            wu_cnt   <= 8'd0;
                            state    <= (WARMUP > 0) ? ST_WARMUP : ST_COLLECT;
                        end else begin
                            rs_cnt <= rs_cnt + 2'd1;
                        end
                    end
                    ST_WARMUP: begin
                        if (wu_cnt == 8'(WARMUP - 1)) begin
                            state <= ST_COLLECT;
                        end else begin
                            wu_cnt <= wu_cnt + 8'd1;
                        end
                    end
                    ST_COLLECT: begin
                        if (pack_last) begin
                            if (!byte_valid || byte_if.BYTE_READY) begin
                                byte_out   <= pack_byte;
                                byte_valid <= 1'b1;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (byte_if.BYTE_READY) begin
                            byte_out   <= pending;
                            byte_valid <= 1'b1;
                            state      <= ST_COLLECT;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Byte completed while the output is still occupied waits here during HOLD.
    always_ff @(posedge CLK) begin
        if (state == ST_COLLECT && pack_last) begin
            pending <= pack_byte;
        end
    end

`ifdef LFSR8_CTRL_PERIOD_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESET || state == ST_RESEED) begin
            PERIOD_CNT <= 8'h00;
        end else if (LFSR_EN && LFSR_PERIOD) begin
            PERIOD_CNT <= sat_inc8(PERIOD_CNT);
        end
    end
`else
    logic unused_period;
    assign unused_period = LFSR_PERIOD;
    assign PERIOD_CNT    = 8'h00;
`endif

endmodule
